// File: rtl/vedic_seq_mul8.sv
// Iterative 8x8 unsigned multiplier driving one shared 4x4 multiplier through four nibble steps.
// Latency 4 edges (8 with PIPE_MUL) from accept to out_valid; result held in DONE until out_ready.
module vedic_seq_mul8 #(
   parameter bit PIPE_MUL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_p,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LL, HL, LH, HH, DONE} state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
   } opnd_t;

   state_t      state, state_nxt;
   opnd_t       opnd, opnd_nxt;
   logic [15:0] acc, acc_nxt;
   logic        phase, phase_nxt;
   logic        stepping;
   logic        step_last;
   logic [15:0] partial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         opnd  <= '0;
         acc   <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_nxt;
         opnd  <= opnd_nxt;
         acc   <= acc_nxt;
         phase <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      opnd_nxt  = opnd;
      acc_nxt   = acc;
      phase_nxt = phase;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      mul_a     = 4'h0;
      mul_b     = 4'h0;
      partial   = 16'h0000;
      stepping  = 1'b0;
      // With a registered multiplier the product of a step arrives on its second cycle.
      step_last = (PIPE_MUL == 1'b0) || phase;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               opnd_nxt.a = in_a;
               opnd_nxt.b = in_b;
               acc_nxt    = 16'h0000;
               phase_nxt  = 1'b0;
               state_nxt  = LL;
            end
         end
         LL: begin
            mul_a    = opnd.a[3:0];
            mul_b    = opnd.b[3:0];
            partial  = {8'h00, mul_p};
            stepping = 1'b1;
            if (step_last) state_nxt = HL;
         end
         HL: begin
            mul_a    = opnd.a[7:4];
            mul_b    = opnd.b[3:0];
            partial  = {4'h0, mul_p, 4'h0};
            stepping = 1'b1;
            if (step_last) state_nxt = LH;
         end
         LH: begin
            mul_a    = opnd.a[3:0];
            mul_b    = opnd.b[7:4];
            partial  = {4'h0, mul_p, 4'h0};
            stepping = 1'b1;
            if (step_last) state_nxt = HH;
         end
         HH: begin
            mul_a    = opnd.a[7:4];
            mul_b    = opnd.b[7:4];
            partial  = {mul_p, 8'h00};
            stepping = 1'b1;
            if (step_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (stepping) begin
         if (step_last) begin
            acc_nxt   = acc + partial;
            phase_nxt = 1'b0;
         end else begin
            phase_nxt = 1'b1;
         end
      end
   end

   assign out_p = acc;

endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Bench for vedic_seq_mul8: one instance per PIPE_MUL setting, each fed by a behavioural 4x4 Vedic multiplier.
module tb_vedic_seq_mul8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        v0 = 1'b0, ir0, ov0, or0 = 1'b0, busy0;
   logic [7:0]  a0 = 8'h00, b0 = 8'h00, mp0;
   logic [3:0]  ma0, mb0;
   logic [15:0] op0;

   logic        v1 = 1'b0, ir1, ov1, or1 = 1'b0, busy1;
   logic [7:0]  a1 = 8'h00, b1 = 8'h00, mp1 = 8'h00;
   logic [3:0]  ma1, mb1;
   logic [15:0] op1;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   // Urdhva-tiryagbhyam: crosswise column sums of bit products, weighted by column.
   function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
      int r = 0;
      for (int k = 0; k < 7; k++) begin
         int s = 0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               if (i + j == k) s += int'(x[i] & y[j]);
         r += s << k;
      end
      return r[7:0];
   endfunction

   assign mp0 = vedic4(ma0, mb0);
   always @(posedge clk) mp1 <= vedic4(ma1, mb1);

   vedic_seq_mul8 #(.PIPE_MUL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_a(a0), .in_b(b0),
      .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .out_valid(ov0), .out_ready(or0),
      .out_p(op0), .busy(busy0)
   );

   vedic_seq_mul8 #(.PIPE_MUL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
      .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .out_valid(ov1), .out_ready(or1),
      .out_p(op1), .busy(busy1)
   );

   function automatic logic [15:0] pop_exp();
      if (sb.size() == 0) return 16'hxxxx;
      return sb.pop_front();
   endfunction

   // Presents a pair to dut0 and returns #1 after its accept edge; the expected product is queued at accept.
   task automatic send0(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      v0 = 1'b1; a0 = a; b0 = b;
      while (!ir0 && n < 20) begin @(posedge clk); #1; n++; end
      if (!ir0) begin
         checks++; failures++;
         $display("FAIL accept_timeout: in_ready=%b required 1", ir0);
      end
      @(posedge clk);
      sb.push_back({8'h00, a} * {8'h00, b});
      #1;
      v0 = 1'b0; a0 = ~a; b0 = ~b;
   endtask

   task automatic wait_out0(output int lat);
      lat = 0;
      while (!ov0 && lat < 40) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL rst_in_ready0: got %b want 1", ir0); end
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_out_valid0: got %b want 0", ov0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy0: got %b want 0", busy0); end
      checks++; if (op0 !== 16'h0) begin failures++; $display("FAIL rst_out_p0: got %h want 0000", op0); end
      checks++; if ({ma0, mb0} !== 8'h00) begin failures++; $display("FAIL rst_mul0: got %h want 00", {ma0, mb0}); end
      checks++; if ({ir1, ov1, busy1} !== 3'b100) begin failures++; $display("FAIL rst_ctrl1: got %b want 100", {ir1, ov1, busy1}); end
      checks++; if (op1 !== 16'h0) begin failures++; $display("FAIL rst_out_p1: got %h want 0000", op1); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sequence();
      int ema[4] = '{2, 1, 2, 1};
      int emb[4] = '{4, 4, 3, 3};
      int eacc[4] = '{16'h0000, 16'h0008, 16'h0048, 16'h00A8};
      logic [15:0] e;
      or0 = 1'b1;
      send0(8'h12, 8'h34);
      for (int k = 0; k < 4; k++) begin
         checks++; if (ma0 !== 4'(ema[k]) || mb0 !== 4'(emb[k])) begin
            failures++; $display("FAIL seq_mul_step%0d: got %h/%h want %h/%h", k, ma0, mb0, ema[k], emb[k]);
         end
         checks++; if (op0 !== 16'(eacc[k]) || ov0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++; $display("FAIL seq_acc_step%0d: got p=%h v=%b busy=%b want p=%h v=0 busy=1", k, op0, ov0, busy0, eacc[k]);
         end
         @(posedge clk); #1;
      end
      e = pop_exp();
      checks++; if (ov0 !== 1'b1 || op0 !== e) begin
         failures++; $display("FAIL seq_result: got v=%b p=%h want v=1 p=%h", ov0, op0, e);
      end
      checks++; if ({ma0, mb0} !== 8'h00) begin failures++; $display("FAIL seq_done_mul: got %h want 00", {ma0, mb0}); end
      @(posedge clk); #1;
      checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
         failures++; $display("FAIL seq_handshake: got v=%b ir=%b want v=0 ir=1", ov0, ir0);
      end
   endtask

   task automatic test_corners();
      logic [7:0] ca[4] = '{8'hFF, 8'h00, 8'h01, 8'h10};
      logic [7:0] cb[4] = '{8'hFF, 8'hA5, 8'h80, 8'h10};
      logic [15:0] e;
      int lat;
      or0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send0(ca[i], cb[i]);
         wait_out0(lat);
         e = pop_exp();
         checks++; if (lat != 4) begin failures++; $display("FAIL corner%0d_latency: got %0d want 4", i, lat); end
         checks++; if (op0 !== e) begin failures++; $display("FAIL corner%0d_result: got %h want %h", i, op0, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] e;
      int lat;
      or0 = 1'b0;
      send0(8'h0F, 8'hF0);
      wait_out0(lat);
      e = pop_exp();
      checks++; if (lat != 4) begin failures++; $display("FAIL bp_latency: got %0d want 4", lat); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (ov0 !== 1'b1 || op0 !== e || ir0 !== 1'b0) begin
            failures++; $display("FAIL bp_hold%0d: got v=%b p=%h ir=%b want v=1 p=%h ir=0", c, ov0, op0, ir0, e);
         end
         v0 = (c != 2); a0 = 8'h55; b0 = 8'h66;
         @(posedge clk); #1;
      end
      v0 = 1'b0; or0 = 1'b1;
      @(posedge clk); #1;
      checks++; if (ir0 !== 1'b1 || ov0 !== 1'b0 || busy0 !== 1'b0 || op0 !== e) begin
         failures++; $display("FAIL bp_release: got ir=%b v=%b busy=%b p=%h want ir=1 v=0 busy=0 p=%h", ir0, ov0, busy0, op0, e);
      end
      // in_valid coinciding with the output handshake must wait for the IDLE cycle
      or0 = 1'b0;
      send0(8'h03, 8'h07);
      wait_out0(lat);
      e = pop_exp();
      checks++; if (op0 !== e) begin failures++; $display("FAIL bp_second: got %h want %h", op0, e); end
      v0 = 1'b1; a0 = 8'h09; b0 = 8'h0B; or0 = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0 || ir0 !== 1'b1) begin
         failures++; $display("FAIL done_no_accept: got busy=%b ir=%b want busy=0 ir=1", busy0, ir0);
      end
      @(posedge clk);
      sb.push_back(16'd99);
      #1; v0 = 1'b0;
      checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL idle_accept: got busy=%b want 1", busy0); end
      wait_out0(lat);
      e = pop_exp();
      checks++; if (ov0 !== 1'b1 || op0 !== e) begin failures++; $display("FAIL idle_accept_result: got v=%b p=%h want v=1 p=%h", ov0, op0, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_pipe();
      logic [3:0] ema[4] = '{4'hB, 4'hA, 4'hB, 4'hA};
      logic [3:0] emb[4] = '{4'hD, 4'hD, 4'hC, 4'hC};
      logic [15:0] e;
      or1 = 1'b1; v1 = 1'b1; a1 = 8'hAB; b1 = 8'hCD;
      @(posedge clk);
      sb.push_back(16'h88EF);
      #1; v1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
      for (int k = 0; k < 8; k++) begin
         checks++; if (ma1 !== ema[k/2] || mb1 !== emb[k/2] || ov1 !== 1'b0) begin
            failures++; $display("FAIL pipe_cycle%0d: got %h/%h v=%b want %h/%h v=0", k, ma1, mb1, ov1, ema[k/2], emb[k/2]);
         end
         @(posedge clk); #1;
      end
      e = pop_exp();
      checks++; if (ov1 !== 1'b1 || op1 !== e) begin
         failures++; $display("FAIL pipe_result: got v=%b p=%h want v=1 p=%h", ov1, op1, e);
      end
      @(posedge clk); #1;
      checks++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin failures++; $display("FAIL pipe_handshake: got v=%b ir=%b want v=0 ir=1", ov1, ir1); end
      or1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      int lat;
      or0 = 1'b1;
      send0(8'h12, 8'h34);
      @(posedge clk); #2;
      checks++; if (ma0 !== 4'h1 || mb0 !== 4'h4) begin failures++; $display("FAIL mid_in_hl: got %h/%h want 1/4", ma0, mb0); end
      rst_n = 1'b0;
      #1;
      checks++; if ({ir0, ov0, busy0} !== 3'b100) begin failures++; $display("FAIL mid_rst_ctrl: got %b want 100", {ir0, ov0, busy0}); end
      checks++; if (op0 !== 16'h0 || {ma0, mb0} !== 8'h00) begin failures++; $display("FAIL mid_rst_data: got p=%h mul=%h want 0000/00", op0, {ma0, mb0}); end
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send0(8'h03, 8'h05);
      wait_out0(lat);
      e = pop_exp();
      checks++; if (lat != 4 || op0 !== e) begin failures++; $display("FAIL mid_after: got lat=%0d p=%h want lat=4 p=%h", lat, op0, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int sent = 0, got = 0, cyc = 0;
      bit acc;
      logic [15:0] e;
      while (got < 1000 && cyc < 40000) begin
         if (!v0 && sent < 1000 && $urandom_range(0, 3) != 0) begin
            v0 = 1'b1; a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
         end
         or0 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = v0 && ir0;
         if (acc) begin sb.push_back({8'h00, a0} * {8'h00, b0}); sent++; end
         if (ov0 && or0) begin
            e = pop_exp();
            checks++; if (op0 !== e) begin failures++; $display("FAIL rand%0d: got %h want %h", got, op0, e); end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) v0 = 1'b0;
      end
      checks++; if (got != 1000) begin failures++; $display("FAIL rand_count: got %0d results want 1000", got); end
      or0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_corners();
      test_backpressure();
      test_pipe();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vedic_seq_mul8.md
Name: vedic_seq_mul8

Overview:
Iterative 8x8 unsigned multiplier built around one external 4x4 Vedic multiplier, our existing combinational block. It accepts an 8-bit operand pair over a valid/ready handshake and drives the four 4-bit nibble products through the shared 4x4 multiplier. It shifts and accumulates the products into a 16-bit result and presents that result on a valid/ready output. It sits directly upstream of the 4x4 multiplier, feeding its a/b inputs, and directly downstream of it, consuming its 8-bit product.

Parameters:
PIPE_MUL, 0, 0 = multiplier product sampled in the same cycle its operands are driven; 1 = product sampled one cycle later, for a registered multiplier output.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  8  multiplicand, unsigned
in_b  input  8  multiplier, unsigned
mul_a  output  4  nibble to 4x4 multiplier a input
mul_b  output  4  nibble to 4x4 multiplier b input
mul_p  input  8  product returned by 4x4 multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_p  output  16  accumulated product
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, mul_a=0, mul_b=0, latched operands=0.
- States: IDLE, LL, HL, LH, HH, DONE.
- Accept: happens on a clk edge with in_valid=1 and in_ready=1.
  - in_ready=1 only in IDLE.
  - On accept: latch in_a and in_b, clear the accumulator (out_p) to 0, go to LL.
  - in_valid while not IDLE is ignored. Changes to in_a/in_b after accept have no effect.
- Steps, using the latched operands:
  - LL: mul_a=a[3:0], mul_b=b[3:0]; acc += mul_p.
  - HL: mul_a=a[7:4], mul_b=b[3:0]; acc += mul_p<<4.
  - LH: mul_a=a[3:0], mul_b=b[7:4]; acc += mul_p<<4.
  - HH: mul_a=a[7:4], mul_b=b[7:4]; acc += mul_p<<8.
- Step timing:
  - PIPE_MUL=0: each step lasts 1 cycle; mul_p is added at the end of that cycle.
  - PIPE_MUL=1: each step lasts 2 cycles. mul_a/mul_b are held for both cycles; mul_p is added only at the end of the second cycle.
- Accumulator width: 16 bits with no overflow possible (max 255*255=0xFE01). Each shifted partial is zero-extended to 16 bits.
- After HH: go to DONE with out_valid=1.
  - out_p equals in_a*in_b and holds stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid=1 and out_ready=1: go to IDLE, out_valid=0.
- out_p is the accumulator register itself. Partial sums are visible during LL..HH; consumers qualify with out_valid. After the output handshake, out_p keeps the final value until the next accept.
- mul_a/mul_b are 0 in IDLE and DONE.
- Latency, from accept edge T to first cycle with out_valid=1: T+4 edges for PIPE_MUL=0, T+8 for PIPE_MUL=1.
- Throughput: a new accept is possible no earlier than the edge after the output handshake, since the block passes through IDLE.
- Reset mid-operation: abort immediately to reset values. No out_valid is ever produced for the aborted operand pair.
- Simultaneous in_valid during DONE together with an out handshake: not accepted. The pair is accepted only in the following IDLE cycle.

Test Plan:
- PIPE_MUL=0, in_a=0x12, in_b=0x34, out_ready=1 -> mul_a/mul_b sequence 2/4, 1/4, 2/3, 1/3. out_p sequence 0x0008, 0x0048, 0x00A8, 0x03A8. out_valid high 4 edges after accept with out_p=0x03A8.
- Corner operands, PIPE_MUL=0: 0xFF*0xFF -> 0xFE01; 0x00*0xA5 -> 0x0000; 0x01*0x80 -> 0x0080; 0x10*0x10 -> 0x0100.
- Backpressure: 0x0F*0xF0, out_ready=0 for 3 cycles after out_valid -> out_valid and out_p=0x0E10 stable for all 3 cycles. in_ready=0 throughout. in_valid pulses in that window are ignored. IDLE is entered the edge after out_ready=1.
- PIPE_MUL=1 with a 1-cycle registered multiplier model, 0xAB*0xCD -> out_valid 8 edges after accept, out_p=0x88EF. Each mul_a/mul_b pair is held 2 cycles.
- Reset mid-operation: assert rst_n=0 during HL of 0x12*0x34 -> all outputs take reset values asynchronously. After release, 0x03*0x05 completes with out_p=0x000F and no stale result.
- Randomized regression: 1000 random pairs with the 4x4 Vedic multiplier connected and random out_ready stalls -> every out_p equals in_a*in_b, in accept order.
